sc_datapath_sequencer: RTL and testbench
========================================

Name: sc_datapath_sequencer

Overview:
Multi-cycle controller for the datapath (general/fixed register file, A/B bus muxes, ALU, shift register, write decoder) in WB_SYSTEM, where it takes the control-unit slot. It accepts one micro-command at a time over a valid/ready handshake. Each command is sequenced as operand select/ALU, shifter load, optional shift, then write-back. In repeat mode the command loops until the ALU Zero flag asserts or an iteration limit is reached.

Parameters:
DATAWIDTH_DECODER_SELECTION, 3, write-decoder select width; code 0 = no write, 1..7 = destination register
DATAWIDTH_MUX_SELECTION, 3, bus A/B mux select width; 0-3 general regs, 4 = fixed reg 0, 5 = fixed reg 1
DATAWIDTH_ALU_SELECTION, 4, ALU operation select width; code 0 = ALU idle/pass
DATAWIDTH_REGSHIFTER_SELECTION, 2, shifter select width
DATAWIDTH_ITER, 8, iteration counter width
MAX_ITER, 255, repeat-mode iteration limit; legal range 1..2^DATAWIDTH_ITER-1

Ports:
SC_DATAPATH_SEQUENCER_CLOCK_50  in  1  system clock, rising edge
SC_DATAPATH_SEQUENCER_Reset_InLow  in  1  asynchronous active-low reset
SC_DATAPATH_SEQUENCER_Cmd_In  in  16  [15:12] ALU op, [11:9] srcA, [8:6] srcB, [5:3] dest, [2:1] shift (00 none, 01 left, 10 right, 11 reserved = none), [0] repeat
SC_DATAPATH_SEQUENCER_CmdValid_In  in  1  command valid
SC_DATAPATH_SEQUENCER_CmdReady_Out  out  1  high only in IDLE
SC_DATAPATH_SEQUENCER_Overflow_InLow / _Carry_InLow / _Negative_InLow / _Zero_InLow  in  1 each  ALU flags, active low
SC_DATAPATH_SEQUENCER_DecoderSelectionWrite_Out  out  3  write-decoder select
SC_DATAPATH_SEQUENCER_MUXSelectionBUSA_Out  out  3  bus A select
SC_DATAPATH_SEQUENCER_MUXSelectionBUSB_Out  out  3  bus B select
SC_DATAPATH_SEQUENCER_ALUSelection_Out  out  4  ALU operation
SC_DATAPATH_SEQUENCER_RegSHIFTERLoad_OutLow  out  1  shifter parallel load, active low
SC_DATAPATH_SEQUENCER_RegSHIFTERShiftSelection_OutLow  out  2  11 idle, 01 shift left, 10 shift right
SC_DATAPATH_SEQUENCER_Busy_Out  out  1  high in any state except IDLE
SC_DATAPATH_SEQUENCER_Done_Out  out  1  one-cycle pulse at command end
SC_DATAPATH_SEQUENCER_Error_Out  out  1  repeat limit hit; valid with Done, held until next accept
SC_DATAPATH_SEQUENCER_Flags_Out  out  4  {V,C,N,Z} captured, active high, held until next capture
SC_DATAPATH_SEQUENCER_IterCount_Out  out  8  ALU passes completed for current/last command

Behaviour:
- Reset (asynchronous, Reset_InLow=0) forces state IDLE immediately. All datapath controls go to idle: decoder 0, muxes 0, ALU 0, Load 1, ShiftSel 11. Ready=1, Busy/Done/Error=0, Flags=0, IterCount=0. Reset mid-command discards the command with no partial write-back.
- Command is latched on the clock edge where the state is IDLE and Valid & Ready. On that same edge IterCount and Error are cleared.
- Outputs are Moore-decoded from the state and the latched command. Every datapath control is at its idle value in any state not listed below.
- OPERAND (1 cycle): MUX A = srcA, MUX B = srcB, ALU = op. At the exiting edge, Flags_Out <= inverted flag inputs and IterCount increments.
- SHIFT_LOAD (1 cycle): MUX/ALU held as in OPERAND, Load=0. Shifter captures the ALU result.
- SHIFT (1 cycle, entered only when shift = 01 or 10): ShiftSel = shift field. Skipped when shift = 00/11.
- WRITEBACK (1 cycle): decoder = dest; dest 0 means no write.
- CHECK (1 cycle, no controls asserted):
  - repeat=1, captured Z=0, IterCount < MAX_ITER -> OPERAND.
  - repeat=1, Z=0, IterCount == MAX_ITER -> DONE with Error=1.
  - Otherwise -> DONE.
- DONE (1 cycle): Done=1 -> IDLE. Ready rises the next cycle.
- Latency from accept edge to Done high: 5 cycles without shift, 6 with shift. Each additional repeat iteration adds 4 or 5 cycles.
- Valid while Busy is ignored; the command must be held by the source until accepted.
- Flag inputs are sampled only at the OPERAND exit edge; changes in other states have no effect.
- IterCount does not wrap, because MAX_ITER bounds it.

Test Plan:
- Reset mid-command: assert Reset_InLow=0 during SHIFT -> same cycle decoder=0, Load=1, ShiftSel=11, Busy=0. After release, Ready=1 and no write-back occurs.
- ADD without shift: Cmd = ALU 0001, srcA 4, srcB 5, dest 1, shift 00, repeat 0; Zero_InLow=1, others 1 -> MUXA=4/MUXB=5 for 2 cycles, Load=0 in cycle 2, decoder=1 in cycle 3, Done in cycle 5, Flags=0000, IterCount=1.
- Left shift: same command with shift 01 -> ShiftSel=01 for exactly one cycle between Load and write-back; Done in cycle 6.
- Repeat until zero: dest 2, repeat 1; TB drives Zero_InLow=0 during the 3rd OPERAND -> 3 write-back pulses, Flags[0]=1, IterCount=3, Error=0.
- Iteration limit: MAX_ITER=4, Zero_InLow held 1, repeat 1 -> 4 iterations, Done with Error=1, IterCount=4. Error clears on the next accept.
- Back-to-back commands: Valid held high with two commands -> second command accepted the cycle after Done; Ready is low throughout the first command.

Source files
------------

// File: rtl/sc_datapath_sequencer_if.sv
// Command handshake, ALU flag inputs and datapath control bundle of the
// WB_SYSTEM datapath sequencer.
interface sc_datapath_sequencer_if #(
    parameter int DATAWIDTH_DECODER_SELECTION    = 3,
    parameter int DATAWIDTH_MUX_SELECTION        = 3,
    parameter int DATAWIDTH_ALU_SELECTION        = 4,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
    parameter int DATAWIDTH_ITER                 = 8
);
    logic [15:0]                               cmd;
    logic                                      cmd_valid;
    logic                                      cmd_ready;
    logic                                      overflow_n;
    logic                                      carry_n;
    logic                                      negative_n;
    logic                                      zero_n;
    logic [DATAWIDTH_DECODER_SELECTION-1:0]    dec_sel;
    logic [DATAWIDTH_MUX_SELECTION-1:0]        mux_a;
    logic [DATAWIDTH_MUX_SELECTION-1:0]        mux_b;
    logic [DATAWIDTH_ALU_SELECTION-1:0]        alu_sel;
    logic                                      load_n;
    logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] shift_sel_n;
    logic                                      busy;
    logic                                      done;
    logic                                      error;
    logic [3:0]                                flags;
    logic [DATAWIDTH_ITER-1:0]                 iter_count;

    // Command source and datapath side.
    modport master (
        output cmd, cmd_valid, overflow_n, carry_n, negative_n, zero_n,
        input  cmd_ready, dec_sel, mux_a, mux_b, alu_sel, load_n, shift_sel_n,
               busy, done, error, flags, iter_count
    );

    // Sequencer side.
    modport slave (
        input  cmd, cmd_valid, overflow_n, carry_n, negative_n, zero_n,
        output cmd_ready, dec_sel, mux_a, mux_b, alu_sel, load_n, shift_sel_n,
               busy, done, error, flags, iter_count
    );
endinterface

// File: rtl/sc_datapath_sequencer.sv
// Multi-cycle micro-command sequencer driving the WB_SYSTEM datapath:
// operand/ALU, shifter load, optional shift, write-back, optional repeat.
module sc_datapath_sequencer #(
    parameter int DATAWIDTH_DECODER_SELECTION    = 3,
    parameter int DATAWIDTH_MUX_SELECTION        = 3,
    parameter int DATAWIDTH_ALU_SELECTION        = 4,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
    parameter int DATAWIDTH_ITER                 = 8,
    parameter int MAX_ITER                       = 255
) (
    input  logic                 SC_DATAPATH_SEQUENCER_CLOCK_50,
    input  logic                 SC_DATAPATH_SEQUENCER_Reset_InLow,
    sc_datapath_sequencer_if.slave bus
);

    localparam logic [DATAWIDTH_ITER-1:0] MAX_ITER_C = DATAWIDTH_ITER'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_OPERAND    = 3'd1,
        S_SHIFT_LOAD = 3'd2,
        S_SHIFT      = 3'd3,
        S_WRITEBACK  = 3'd4,
        S_CHECK      = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t                                    state_q, state_d;
    logic [15:0]                               cmd_q, cmd_d;
    logic [3:0]                                flags_q, flags_d;
    logic [DATAWIDTH_ITER-1:0]                 iter_q, iter_d;
    logic                                      error_q, error_d;
    logic [DATAWIDTH_DECODER_SELECTION-1:0]    dec_q, dec_d;
    logic [DATAWIDTH_MUX_SELECTION-1:0]        mux_a_q, mux_a_d;
    logic [DATAWIDTH_MUX_SELECTION-1:0]        mux_b_q, mux_b_d;
    logic [DATAWIDTH_ALU_SELECTION-1:0]        alu_q, alu_d;
    logic                                      load_n_q, load_n_d;
    logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] shsel_n_q, shsel_n_d;
    logic                                      ready_q, ready_d;
    logic                                      busy_q, busy_d;
    logic                                      done_q, done_d;

    // Fields of the held command (state decisions) and of the next command (output decode).
    logic [1:0] cur_shift_s;
    logic       cur_repeat_s;
    logic       cur_shift_en_s;
    logic [1:0] nxt_shift_s;

    assign cur_shift_s    = cmd_q[2:1];
    assign cur_repeat_s   = cmd_q[0];
    assign cur_shift_en_s = (cur_shift_s == 2'b01) || (cur_shift_s == 2'b10);
    assign nxt_shift_s    = cmd_d[2:1];

    // Next-state, command latch, flag capture and iteration bookkeeping.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        flags_d = flags_q;
        iter_d  = iter_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    cmd_d   = bus.cmd;
                    iter_d  = '0;
                    error_d = 1'b0;
                    state_d = S_OPERAND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OPERAND: begin
                flags_d = ~{bus.overflow_n, bus.carry_n, bus.negative_n, bus.zero_n};
                iter_d  = iter_q + DATAWIDTH_ITER'(1);
                state_d = S_SHIFT_LOAD;
            end
            S_SHIFT_LOAD: begin
                if (cur_shift_en_s) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_SHIFT:     state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = S_CHECK;
            S_CHECK: begin
                // Loop only while repeating and the captured Zero flag is still clear.
                if (cur_repeat_s && !flags_q[0]) begin
                    if (iter_q < MAX_ITER_C) begin
                        state_d = S_OPERAND;
                    end else begin
                        state_d = S_DONE;
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode from the upcoming state so outputs come straight from flops.
    always_comb begin
        dec_d     = '0;
        mux_a_d   = '0;
        mux_b_d   = '0;
        alu_d     = '0;
        load_n_d  = 1'b1;
        shsel_n_d = 2'b11;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        busy_d    = 1'b1;
        case (state_d)
            S_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            S_OPERAND: begin
                mux_a_d = cmd_d[11:9];
                mux_b_d = cmd_d[8:6];
                alu_d   = cmd_d[15:12];
            end
            S_SHIFT_LOAD: begin
                mux_a_d  = cmd_d[11:9];
                mux_b_d  = cmd_d[8:6];
                alu_d    = cmd_d[15:12];
                load_n_d = 1'b0;
            end
            S_SHIFT:     shsel_n_d = nxt_shift_s;
            S_WRITEBACK: dec_d     = cmd_d[5:3];
            S_CHECK:     busy_d    = 1'b1;
            S_DONE:      done_d    = 1'b1;
            default:     busy_d    = 1'b1;
        endcase
    end

    // Single state/output register bank; async reset returns everything to idle.
    always_ff @(posedge SC_DATAPATH_SEQUENCER_CLOCK_50 or negedge SC_DATAPATH_SEQUENCER_Reset_InLow) begin
        if (!SC_DATAPATH_SEQUENCER_Reset_InLow) begin
            state_q   <= S_IDLE;
            cmd_q     <= 16'h0000;
            flags_q   <= 4'b0000;
            iter_q    <= '0;
            error_q   <= 1'b0;
            dec_q     <= '0;
            mux_a_q   <= '0;
            mux_b_q   <= '0;
            alu_q     <= '0;
            load_n_q  <= 1'b1;
            shsel_n_q <= 2'b11;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            flags_q   <= flags_d;
            iter_q    <= iter_d;
            error_q   <= error_d;
            dec_q     <= dec_d;
            mux_a_q   <= mux_a_d;
            mux_b_q   <= mux_b_d;
            alu_q     <= alu_d;
            load_n_q  <= load_n_d;
            shsel_n_q <= shsel_n_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.cmd_ready   = ready_q;
    assign bus.dec_sel     = dec_q;
    assign bus.mux_a       = mux_a_q;
    assign bus.mux_b       = mux_b_q;
    assign bus.alu_sel     = alu_q;
    assign bus.load_n      = load_n_q;
    assign bus.shift_sel_n = shsel_n_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.flags       = flags_q;
    assign bus.iter_count  = iter_q;

endmodule

// File: tb/tb_sc_datapath_sequencer.sv
// Scoreboard bench for sc_datapath_sequencer: per-cycle expected control
// vectors are queued at command issue and compared as the DUT steps.
module tb_sc_datapath_sequencer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    sc_datapath_sequencer_if bus ();

    sc_datapath_sequencer #(.MAX_ITER(4)) dut (
        .SC_DATAPATH_SEQUENCER_CLOCK_50    (clk),
        .SC_DATAPATH_SEQUENCER_Reset_InLow (rst_n),
        .bus                               (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] vec;   // {dec, muxA, muxB, alu, load_n, shsel_n, done}
        logic        is_op;
        int          iter;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [15:0] mk_cmd(input logic [3:0] op, input logic [2:0] a,
                                           input logic [2:0] b, input logic [2:0] d,
                                           input logic [1:0] sh, input logic rep);
        return {op, a, b, d, sh, rep};
    endfunction

    function automatic exp_t mk_exp(input logic [16:0] vec, input logic is_op, input int iter);
        exp_t e;
        e.vec   = vec;
        e.is_op = is_op;
        e.iter  = iter;
        return e;
    endfunction

    function automatic logic [16:0] act_vec();
        return {bus.dec_sel, bus.mux_a, bus.mux_b, bus.alu_sel, bus.load_n, bus.shift_sel_n, bus.done};
    endfunction

    task automatic set_flags_n(input logic [3:0] f);
        {bus.overflow_n, bus.carry_n, bus.negative_n, bus.zero_n} = f;
    endtask

    // Issue one command, queue its expected per-cycle trace, then step and compare.
    task automatic run_cmd(input string name, input logic [15:0] c, input int n_iter,
                           input int zero_iter, input logic [2:0] vcn_n, input logic exp_err,
                           input logic hold, input logic [15:0] nxt);
        exp_t        e;
        logic        first;
        int          cyc;
        logic [3:0]  exp_flags;
        logic        shift_en;
        shift_en = (c[2:1] == 2'b01) || (c[2:1] == 2'b10);
        for (int it = 1; it <= n_iter; it++) begin
            sb_q.push_back(mk_exp({3'd0, c[11:9], c[8:6], c[15:12], 1'b1, 2'b11, 1'b0}, 1'b1, it));
            sb_q.push_back(mk_exp({3'd0, c[11:9], c[8:6], c[15:12], 1'b0, 2'b11, 1'b0}, 1'b0, it));
            if (shift_en)
                sb_q.push_back(mk_exp({3'd0, 3'd0, 3'd0, 4'd0, 1'b1, c[2:1], 1'b0}, 1'b0, it));
            sb_q.push_back(mk_exp({c[5:3], 3'd0, 3'd0, 4'd0, 1'b1, 2'b11, 1'b0}, 1'b0, it));
            sb_q.push_back(mk_exp({3'd0, 3'd0, 3'd0, 4'd0, 1'b1, 2'b11, 1'b0}, 1'b0, it));
        end
        sb_q.push_back(mk_exp({3'd0, 3'd0, 3'd0, 4'd0, 1'b1, 2'b11, 1'b1}, 1'b0, n_iter));
        exp_flags = ~{vcn_n, (zero_iter == n_iter) ? 1'b0 : 1'b1};

        n_checks++;
        if (bus.cmd_ready !== 1'b1)
            $display("FAIL %s ready_before_accept: got %b want 1", name, bus.cmd_ready);
        else
            n_pass++;

        bus.cmd       = c;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        if (hold) bus.cmd = nxt;
        else bus.cmd_valid = 1'b0;

        first = 1'b1;
        cyc   = 1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (act_vec() !== e.vec)
                $display("FAIL %s ctrl cycle %0d: got %h want %h", name, cyc, act_vec(), e.vec);
            else
                n_pass++;
            n_checks++;
            if ({bus.busy, bus.cmd_ready} !== 2'b10)
                $display("FAIL %s busy_ready cycle %0d: got %b want 10", name, cyc, {bus.busy, bus.cmd_ready});
            else
                n_pass++;
            if (first) begin
                n_checks++;
                if ({bus.error, bus.iter_count} !== {1'b0, 8'd0})
                    $display("FAIL %s cleared_on_accept: got err=%b iter=%0d want err=0 iter=0",
                             name, bus.error, bus.iter_count);
                else
                    n_pass++;
                first = 1'b0;
            end
            if (e.vec[0]) begin
                n_checks++;
                if ({bus.error, bus.flags, bus.iter_count} !== {exp_err, exp_flags, 8'(n_iter)})
                    $display("FAIL %s result: got err=%b flags=%b iter=%0d want err=%b flags=%b iter=%0d",
                             name, bus.error, bus.flags, bus.iter_count, exp_err, exp_flags, n_iter);
                else
                    n_pass++;
            end
            // Real flags only during OPERAND; inverted noise elsewhere must be ignored.
            if (e.is_op)
                set_flags_n({vcn_n, (e.iter == zero_iter) ? 1'b0 : 1'b1});
            else
                set_flags_n({~vcn_n, 1'b0});
            @(posedge clk); #1;
            cyc++;
        end
        set_flags_n(4'b1111);

        n_checks++;
        if ({bus.busy, bus.cmd_ready, bus.done} !== 3'b010)
            $display("FAIL %s idle_after_done: got %b want 010", name, {bus.busy, bus.cmd_ready, bus.done});
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.cmd       = 16'h0000;
        bus.cmd_valid = 1'b0;
        set_flags_n(4'b1111);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({act_vec(), bus.cmd_ready, bus.busy, bus.error, bus.flags, bus.iter_count} !==
            {3'd0, 3'd0, 3'd0, 4'd0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0})
            $display("FAIL reset_state: got ctrl=%h rdy=%b busy=%b err=%b flags=%b iter=%0d",
                     act_vec(), bus.cmd_ready, bus.busy, bus.error, bus.flags, bus.iter_count);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_no_shift();
        run_cmd("add_no_shift", mk_cmd(4'b0001, 3'd4, 3'd5, 3'd1, 2'b00, 1'b0), 1, 0, 3'b111, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_left_shift();
        run_cmd("left_shift", mk_cmd(4'b0001, 3'd4, 3'd5, 3'd1, 2'b01, 1'b0), 1, 0, 3'b111, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_right_and_reserved_shift();
        run_cmd("right_shift", mk_cmd(4'b0110, 3'd2, 3'd3, 3'd7, 2'b10, 1'b0), 1, 0, 3'b111, 1'b0, 1'b0, 16'h0);
        run_cmd("reserved_shift_dest0", mk_cmd(4'b1010, 3'd1, 3'd0, 3'd0, 2'b11, 1'b0), 1, 0, 3'b111, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_flag_capture();
        run_cmd("flag_capture", mk_cmd(4'b0011, 3'd0, 3'd1, 3'd3, 2'b00, 1'b0), 1, 1, 3'b010, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_repeat_until_zero();
        run_cmd("repeat_zero", mk_cmd(4'b0010, 3'd2, 3'd4, 3'd2, 2'b00, 1'b1), 3, 3, 3'b111, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_iter_limit();
        run_cmd("iter_limit", mk_cmd(4'b0100, 3'd1, 3'd5, 3'd3, 2'b10, 1'b1), 4, 0, 3'b111, 1'b1, 1'b0, 16'h0);
        run_cmd("error_clear", mk_cmd(4'b0001, 3'd3, 3'd2, 3'd4, 2'b00, 1'b0), 1, 0, 3'b111, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] c1;
        logic [15:0] c2;
        c1 = mk_cmd(4'b0101, 3'd0, 3'd1, 3'd5, 2'b01, 1'b0);
        c2 = mk_cmd(4'b1001, 3'd5, 3'd4, 3'd6, 2'b00, 1'b0);
        run_cmd("b2b_first", c1, 1, 0, 3'b111, 1'b0, 1'b1, c2);
        run_cmd("b2b_second", c2, 1, 0, 3'b111, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_reset_mid_command();
        bus.cmd       = mk_cmd(4'b0001, 3'd4, 3'd5, 3'd1, 2'b01, 1'b0);
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.shift_sel_n !== 2'b01)
            $display("FAIL reset_mid in_shift: got %b want 01", bus.shift_sel_n);
        else
            n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.dec_sel, bus.load_n, bus.shift_sel_n, bus.busy, bus.cmd_ready} !== {3'd0, 1'b1, 2'b11, 1'b0, 1'b1})
            $display("FAIL reset_mid async: got dec=%0d ld=%b sh=%b busy=%b rdy=%b",
                     bus.dec_sel, bus.load_n, bus.shift_sel_n, bus.busy, bus.cmd_ready);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.dec_sel, bus.busy, bus.cmd_ready, bus.done} !== {3'd0, 1'b0, 1'b1, 1'b0})
                $display("FAIL reset_mid no_writeback cycle %0d: got dec=%0d busy=%b rdy=%b done=%b",
                         i, bus.dec_sel, bus.busy, bus.cmd_ready, bus.done);
            else
                n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_add_no_shift();
        test_left_shift();
        test_right_and_reserved_shift();
        test_flag_capture();
        test_repeat_until_zero();
        test_iter_limit();
        test_back_to_back();
        test_reset_mid_command();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
